// File: rtl/reg_file_link_wb.sv
// Architectural register file with a general write port and a buffered link port.
// Optional read-path forwarding of in-flight writes is enabled with `define BYPASS_EN.
module reg_file_link_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    output logic              busy,
    output logic              link_ovf
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_pend_vld;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_link_ovf;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_fill;
    logic              w_retire;
    logic              w_ovf_evt;

    // One physical write per clock: general port, then the parked link, then a direct link.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (wr_en) begin
            w_we    = 1'b1;
            w_waddr = wr_addr;
            w_wdata = wr_data;
        end else if (r_pend_vld) begin
            w_we    = 1'b1;
            w_waddr = LINK_IDX;
            w_wdata = r_pend_data;
        end else if (link_en) begin
            w_we    = 1'b1;
            w_waddr = LINK_IDX;
            w_wdata = link_data;
        end
    end

    assign w_fill    = wr_en & link_en & ~r_pend_vld;
    assign w_retire  = r_pend_vld & ~wr_en;
    assign w_ovf_evt = link_en & r_pend_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we && (w_waddr != '0)) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
        end else if (w_fill) begin
            r_pend_vld  <= 1'b1;
            r_pend_data <= link_data;
        end else if (w_retire) begin
            r_pend_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_link_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_link_ovf <= 1'b1;
        end
    end

    assign busy     = r_pend_vld;
    assign link_ovf = r_link_ovf;

`ifdef BYPASS_EN
    logic w_link_direct;

    assign w_link_direct = link_en & ~r_pend_vld & ~wr_en;

    always_comb begin
        rs_data = r_regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wr_en && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end else if (r_pend_vld && (rs_addr == LINK_IDX)) begin
            rs_data = r_pend_data;
        end else if (w_link_direct && (rs_addr == LINK_IDX)) begin
            rs_data = link_data;
        end
    end

    always_comb begin
        rt_data = r_regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wr_en && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end else if (r_pend_vld && (rt_addr == LINK_IDX)) begin
            rt_data = r_pend_data;
        end else if (w_link_direct && (rt_addr == LINK_IDX)) begin
            rt_data = link_data;
        end
    end
`else
    assign rs_data = (rs_addr == '0) ? '0 : r_regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : r_regs[rt_addr];
`endif

endmodule

// File: tb/tb_reg_file_link_wb.sv
// Randomized bench for reg_file_link_wb against a queue-based reference model.
module tb_reg_file_link_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        link_en;
    logic [31:0] link_data;
    logic        busy, link_ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend [$];
    logic        m_ovf;

    logic [31:0] g_rs, g_rt, g_busy, g_ovf;

    always #5 clk = ~clk;

    reg_file_link_wb dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .link_en  (link_en),
        .link_data(link_data),
        .busy     (busy),
        .link_ovf (link_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
        if (m_pend.size() != 0 && a == 5'd31) return m_pend[0];
        if (link_en && m_pend.size() == 0 && !wr_en && a == 5'd31)
            return link_data;
`endif
        return m_regs[a];
    endfunction

    task automatic m_clock();
        bit had;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_pend.delete();
            m_ovf = 1'b0;
            return;
        end
        had = (m_pend.size() != 0);
        if (wr_en) begin
            if (wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
        end else if (had) begin
            m_regs[31] = m_pend.pop_front();
        end else if (link_en) begin
            m_regs[31] = link_data;
        end
        if (link_en) begin
            if (had) m_ovf = 1'b1;
            else if (wr_en) m_pend.push_back(link_data);
        end
    endtask

    task automatic step(input logic i_rst, input logic i_we,
                        input logic [4:0] i_wa, input logic [31:0] i_wd,
                        input logic i_le, input logic [31:0] i_ld,
                        input logic [4:0] i_rs, input logic [4:0] i_rt);
        @(negedge clk);
        rst = i_rst; wr_en = i_we; wr_addr = i_wa; wr_data = i_wd;
        link_en = i_le; link_data = i_ld; rs_addr = i_rs; rt_addr = i_rt;
        #1;
        g_rs = rs_data; g_rt = rt_data;
        g_busy = {31'h0, busy}; g_ovf = {31'h0, link_ovf};
        if (!i_rst) begin
            chk("m_rs", rs_data, m_read(i_rs));
            chk("m_rt", rt_data, m_read(i_rt));
            chk("m_busy", {31'h0, busy}, {31'h0, m_pend.size() != 0});
            chk("m_ovf", {31'h0, link_ovf}, {31'h0, m_ovf});
        end
        @(posedge clk);
        m_clock();
    endtask

    task automatic idle(input logic [4:0] i_rs, input logic [4:0] i_rt);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, i_rs, i_rt);
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_ovf = 1'b0;
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);

        for (int i = 0; i < 16; i++) begin
            idle(5'(i), 5'(i + 16));
            chk("rst_rs", g_rs, 32'h0);
            chk("rst_rt", g_rt, 32'h0);
        end
        chk("rst_busy", g_busy, 32'h0);
        chk("rst_ovf", g_ovf, 32'h0);

        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 5'd0, 5'd0);
        idle(5'd5, 5'd0);
        chk("wr_r5", g_rs, 32'hDEADBEEF);
        step(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 32'h0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("wr_r0", g_rs, 32'h0);

        step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 32'h400, 5'd0, 5'd0);
        idle(5'd3, 5'd0);
        chk("col_busy1", g_busy, 32'h1);
        chk("col_r3", g_rs, 32'h11);
        idle(5'd3, 5'd31);
        chk("col_busy0", g_busy, 32'h0);
        chk("col_r31", g_rt, 32'h400);

        step(1'b0, 1'b1, 5'd4, 32'h22, 1'b1, 32'h404, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 5'(10 + i), 32'(i), 1'b0, 32'h0, 5'd0, 5'd0);
            chk("hold_busy", g_busy, 32'h1);
        end
        idle(5'd0, 5'd0);
        chk("hold_last", g_busy, 32'h1);
        idle(5'd4, 5'd31);
        chk("hold_done", g_busy, 32'h0);
        chk("hold_r31", g_rt, 32'h404);

        step(1'b0, 1'b1, 5'd8, 32'h33, 1'b1, 32'h440, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd9, 32'h44, 1'b1, 32'h800, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("ovf_set", g_ovf, 32'h1);
        idle(5'd31, 5'd9);
        chk("ovf_r31", g_rs, 32'h440);
        chk("ovf_sticky", g_ovf, 32'h1);

        step(1'b0, 1'b1, 5'd2, 32'h66, 1'b1, 32'h500, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
        chk("rstmid_busy_pre", g_busy, 32'h1);
        idle(5'd31, 5'd2);
        chk("rstmid_r31", g_rs, 32'h0);
        chk("rstmid_r2", g_rt, 32'h0);
        chk("rstmid_busy", g_busy, 32'h0);
        chk("rstmid_ovf", g_ovf, 32'h0);

`ifdef BYPASS_EN
        step(1'b0, 1'b1, 5'd7, 32'h55, 1'b0, 32'h0, 5'd7, 5'd0);
        chk("byp_r7", g_rs, 32'h55);
`endif

        for (int n = 0; n < 2000; n++) begin
            logic [4:0] ra, rb;
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                 $urandom,
                 $urandom_range(0, 9) < 3,
                 $urandom, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
